// File: rtl/multicycle_control_unit_if.sv
// Data-path <-> main-control bundle: instruction fields and Zero in, control strobes out.
// Latency: none, plain wires.
// Backpressure: none; strobes are sampled by the data path every clk_dp edge.
interface multicycle_control_unit_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       Zero;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       PCSrc;
  logic       ALUSrcA;
  logic       MemtoReg;
  logic       RegDst;
  logic       PCene;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUSControl;

  // Control unit side
  modport master (
    input  op, funct, Zero,
    output IorD, MemWrite, IRWrite, RegWrite, PCSrc, ALUSrcA, MemtoReg,
           RegDst, PCene, ALUSrcB, ALUSControl
  );

  // Data-path side
  modport slave (
    output op, funct, Zero,
    input  IorD, MemWrite, IRWrite, RegWrite, PCSrc, ALUSrcA, MemtoReg,
           RegDst, PCene, ALUSrcB, ALUSControl
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS main-control FSM + ALU decoder with retired-instruction counter.
// Latency: strobes follow the current state (Zero/funct pass through combinationally).
// Backpressure: none; advances one state per clk_dp edge, reset zeroes every strobe.
module multicycle_control_unit #(
  parameter int CNT_W = 32
) (
  input  logic                      clk_dp,
  input  logic                      rst,
  multicycle_control_unit_if.master dp,
  output logic                      instr_done,
  output logic [CNT_W-1:0]          instr_count,
  output logic [3:0]                state_o
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       pc_src;
    logic       alu_src_a;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       pc_en;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctl;
    logic       done;
  } ctl_t;

  // State kept as a plain vector so illegal codes 11..15 are representable.
  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  ctl_t             ctl, ctl_o;
  logic [2:0]       rtype_alu;

  // R-type funct decode; unknown funct falls back to add
  always_comb begin
    rtype_alu = ALU_ADD;
    case (dp.funct)
      6'b100000: rtype_alu = ALU_ADD;
      6'b100010: rtype_alu = ALU_SUB;
      6'b100100: rtype_alu = ALU_AND;
      6'b100101: rtype_alu = ALU_OR;
      6'b101010: rtype_alu = ALU_SLT;
      default:   rtype_alu = ALU_ADD;
    endcase
  end

  // Next-state and per-state strobes; unlisted strobes stay 0
  always_comb begin
    ctl     = '0;
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: begin
        ctl.ir_write  = 1'b1;
        ctl.alu_src_b = 2'b01;
        ctl.alu_ctl   = ALU_ADD;
        ctl.pc_en     = 1'b1;
        state_d       = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is computed here speculatively into ALUOut
        ctl.alu_src_b = 2'b11;
        ctl.alu_ctl   = ALU_ADD;
        case (dp.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_FETCH;  // unsupported op retires as a silent NOP
        endcase
      end
      S_MEMADR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
        ctl.alu_ctl   = ALU_ADD;
        state_d       = (dp.op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        ctl.iord = 1'b1;
        state_d  = S_MEMWB;
      end
      S_MEMWB: begin
        ctl.mem_to_reg = 1'b1;
        ctl.reg_write  = 1'b1;
        ctl.done       = 1'b1;
      end
      S_MEMWR: begin
        ctl.iord      = 1'b1;
        ctl.mem_write = 1'b1;
        ctl.done      = 1'b1;
      end
      S_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_ctl   = rtype_alu;
        state_d       = S_ALUWB;
      end
      S_ALUWB: begin
        ctl.reg_dst   = 1'b1;
        ctl.reg_write = 1'b1;
        ctl.done      = 1'b1;
      end
      S_BRANCH: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_ctl   = ALU_SUB;
        ctl.pc_src    = 1'b1;
        ctl.pc_en     = dp.Zero;
        ctl.done      = 1'b1;  // retires whether or not the branch is taken
      end
      S_ADDIEX: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
        ctl.alu_ctl   = ALU_ADD;
        state_d       = S_ADDIWB;
      end
      S_ADDIWB: begin
        ctl.reg_write = 1'b1;
        ctl.done      = 1'b1;
      end
      default: begin
        ctl     = '0;
        state_d = S_FETCH;
      end
    endcase
  end

  // Reset gates the strobes immediately, before the state register sees an edge
  assign ctl_o = rst ? ctl : '0;

  assign dp.IorD        = ctl_o.iord;
  assign dp.MemWrite    = ctl_o.mem_write;
  assign dp.IRWrite     = ctl_o.ir_write;
  assign dp.RegWrite    = ctl_o.reg_write;
  assign dp.PCSrc       = ctl_o.pc_src;
  assign dp.ALUSrcA     = ctl_o.alu_src_a;
  assign dp.MemtoReg    = ctl_o.mem_to_reg;
  assign dp.RegDst      = ctl_o.reg_dst;
  assign dp.PCene       = ctl_o.pc_en;
  assign dp.ALUSrcB     = ctl_o.alu_src_b;
  assign dp.ALUSControl = ctl_o.alu_ctl;
  assign instr_done     = ctl_o.done;
  assign instr_count    = count_q;
  assign state_o        = state_q;

  // Retired-instruction count, wraps naturally at 2^CNT_W
  always_comb begin
    count_d = count_q + CNT_W'(ctl_o.done);
  end

  // State and counter registers
  always_ff @(posedge clk_dp or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: instruction-level model expands each instruction
// into its expected per-cycle strobe sequence; one process compares every cycle.
// Stimulus changes just after posedge, comparisons happen on negedge.
module tb_multicycle_control_unit;

  logic        clk;
  logic        rst_n;
  logic        instr_done;
  logic [31:0] instr_count;
  logic [3:0]  state_o;

  multicycle_control_unit_if dpif();

  multicycle_control_unit #(.CNT_W(32)) dut (
    .clk_dp      (clk),
    .rst         (rst_n),
    .dp          (dpif),
    .instr_done  (instr_done),
    .instr_count (instr_count),
    .state_o     (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  st;
    logic        iord;
    logic        memwrite;
    logic        irwrite;
    logic        regwrite;
    logic        pcsrc;
    logic        alusrca;
    logic        memtoreg;
    logic        regdst;
    logic        pcene;
    logic [1:0]  alusrcb;
    logic [2:0]  aluctl;
    logic        done;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic [31:0] model_cnt = 0;

  logic [5:0] f_tab[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [2:0] a_tab[5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

  function automatic logic [2:0] alu_of(input logic [5:0] f);
    logic [2:0] r = 3'b010;
    for (int i = 0; i < 5; i++) if (f_tab[i] == f) r = a_tab[i];
    return r;
  endfunction

  function automatic exp_t blank(input logic [3:0] st);
    exp_t e = '0;
    e.st  = st;
    e.cnt = model_cnt;
    return e;
  endfunction

  // Drive one instruction from FETCH; expand it into expected cycles and wait
  // for up to max_cyc of them. Returns the full instruction length.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int max_cyc, output int len);
    exp_t seq[$];
    exp_t e;
    int   n;
    dpif.op    = o;
    dpif.funct = f;
    dpif.Zero  = z;
    e = blank(0); e.irwrite = 1; e.alusrcb = 2'b01; e.aluctl = 3'b010; e.pcene = 1;
    seq.push_back(e);
    e = blank(1); e.alusrcb = 2'b11; e.aluctl = 3'b010;
    seq.push_back(e);
    if (o == 6'b100011 || o == 6'b101011) begin
      e = blank(2); e.alusrca = 1; e.alusrcb = 2'b10; e.aluctl = 3'b010;
      seq.push_back(e);
      if (o == 6'b100011) begin
        e = blank(3); e.iord = 1; seq.push_back(e);
        e = blank(4); e.memtoreg = 1; e.regwrite = 1; e.done = 1; seq.push_back(e);
      end else begin
        e = blank(5); e.iord = 1; e.memwrite = 1; e.done = 1; seq.push_back(e);
      end
    end else if (o == 6'b000000) begin
      e = blank(6); e.alusrca = 1; e.aluctl = alu_of(f); seq.push_back(e);
      e = blank(7); e.regdst = 1; e.regwrite = 1; e.done = 1; seq.push_back(e);
    end else if (o == 6'b000100) begin
      e = blank(8); e.alusrca = 1; e.aluctl = 3'b110; e.pcsrc = 1; e.pcene = z; e.done = 1;
      seq.push_back(e);
    end else if (o == 6'b001000) begin
      e = blank(9); e.alusrca = 1; e.alusrcb = 2'b10; e.aluctl = 3'b010; seq.push_back(e);
      e = blank(10); e.regwrite = 1; e.done = 1; seq.push_back(e);
    end
    len = seq.size();
    n = (max_cyc < len) ? max_cyc : len;
    for (int i = 0; i < n; i++) exp_q.push_back(seq[i]);
    if (n == len && seq[len-1].done) model_cnt = model_cnt + 1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pin_len(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL len_%s got %0d want %0d", name, got, want);
    end
  endtask

  // Per-cycle compare against the model's expected cycle
  exp_t act, exq;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exq = exp_q.pop_front();
      act = '{state_o, dpif.IorD, dpif.MemWrite, dpif.IRWrite, dpif.RegWrite, dpif.PCSrc,
              dpif.ALUSrcA, dpif.MemtoReg, dpif.RegDst, dpif.PCene, dpif.ALUSrcB,
              dpif.ALUSControl, instr_done, instr_count};
      checks++;
      if (act !== exq) begin
        errors++;
        $display("FAIL cyc t=%0t state got %0d want %0d; ctl got %h want %h; cnt got %0d want %0d",
                 $time, act.st, exq.st, act[37:32], exq[37:32], act.cnt, exq.cnt);
      end
      checks++;
      if (dpif.MemWrite && dpif.RegWrite) begin
        errors++;
        $display("FAIL excl t=%0t MemWrite and RegWrite both 1", $time);
      end
    end
  end

  int   len;
  exp_t e;
  int   k;
  logic [5:0] o, f;

  initial begin
    rst_n      = 1'b0;
    dpif.op    = 6'b100011;
    dpif.funct = 6'b000000;
    dpif.Zero  = 1'b0;
    @(posedge clk); #1;
    // Reset held three cycles: everything zero, state FETCH
    for (int i = 0; i < 3; i++) exp_q.push_back(blank(0));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed: lw, with literal pins on the model and the counter
    run_instr(6'b100011, 6'h00, 1'b0, 99, len); pin_len("lw", len, 5);
    checks++;
    if (instr_count !== 32'd1) begin
      errors++;
      $display("FAIL lw_count got %0d want 1", instr_count);
    end
    foreach (f_tab[i]) begin
      run_instr(6'b000000, f_tab[i], 1'b0, 99, len); pin_len("rtype", len, 4);
    end
    checks++;
    if (alu_of(6'b101010) != 3'b111 || alu_of(6'b111111) != 3'b010) begin
      errors++;
      $display("FAIL alu_model slt got %b unk got %b want 111/010", alu_of(6'b101010), alu_of(6'b111111));
    end
    run_instr(6'b000100, 6'h00, 1'b1, 99, len); pin_len("beq_t", len, 3);
    run_instr(6'b000100, 6'h00, 1'b0, 99, len); pin_len("beq_nt", len, 3);
    run_instr(6'b101011, 6'h00, 1'b0, 99, len); pin_len("sw", len, 4);
    run_instr(6'b001000, 6'h00, 1'b0, 99, len); pin_len("addi", len, 4);
    run_instr(6'b111111, 6'h00, 1'b0, 99, len); pin_len("nop", len, 2);
    checks++;
    if (model_cnt != 32'd10) begin
      errors++;
      $display("FAIL model_cnt got %0d want 10", model_cnt);
    end

    // Reset asserted in the MEMRD cycle of an lw
    run_instr(6'b100011, 6'h00, 1'b0, 3, len);
    rst_n     = 1'b0;
    model_cnt = 0;
    exp_q.push_back(blank(0));
    exp_q.push_back(blank(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Illegal state 12 forced in place of DECODE of an unsupported op
    run_instr(6'b111111, 6'h00, 1'b0, 1, len);
    force dut.state_q = 4'd12;
    exp_q.push_back(blank(12));
    @(negedge clk); #1;
    release dut.state_q;
    @(posedge clk); #1;

    // Randomized instruction stream
    for (int n = 0; n < 80; n++) begin
      k = $urandom_range(0, 5);
      f = ($urandom_range(0, 4) == 0) ? 6'($urandom) : f_tab[$urandom_range(0, 4)];
      case (k)
        0: o = 6'b100011;
        1: o = 6'b101011;
        2: o = 6'b000000;
        3: o = 6'b000100;
        4: o = 6'b001000;
        default: begin
          o = 6'($urandom);
          if (o == 6'b100011 || o == 6'b101011 || o == 6'b000000 ||
              o == 6'b000100 || o == 6'b001000) o = 6'b111110;
        end
      endcase
      run_instr(o, f, 1'($urandom), 99, len);
    end

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
